mips_hilo_muldiv: RTL and testbench
===================================

Name: mips_hilo_muldiv

Overview:
Multi-cycle multiply/divide unit with the architectural HI/LO registers. It consumes the two register-file read operands (rs on op_a, rt on op_b) for MULT/MULTU/DIV/DIVU. It accepts MTHI/MTLO writes and presents HI/LO for MFHI/MFLO, whose results return to the register file write port. The pipeline control stalls on busy before issuing any HI/LO read.

Parameters:
DATA_W, 32, operand and HI/LO width. Only 32 is supported.
ITER, 32, iterations per operation. Must equal DATA_W.

Ports:
CLK  in  1  clock.
rst  in  1  synchronous reset, active-high.
start  in  1  launch the operation selected by op. Sampled only in IDLE.
op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
op_a  in  32  rs operand (multiplicand / dividend).
op_b  in  32  rt operand (multiplier / divisor).
hi_we  in  1  MTHI strobe.
lo_we  in  1  MTLO strobe.
wr_data  in  32  MTHI/MTLO data.
busy  out  1  high while an operation is in flight (state != IDLE).
done  out  1  one-cycle pulse: HI/LO have just been updated by an operation.
hi  out  32  architectural HI.
lo  out  32  architectural LO.

Behaviour:
Reset: rst sampled high clears HI, LO, all working registers and the counter, sets state to IDLE, and drives busy=0, done=0. Reset mid-operation aborts the operation; no done pulse follows.
States: IDLE -> RUN -> FIX -> IDLE.
IDLE:
start=1 latches the operand magnitudes (two's-complement absolute value for MULT/DIV; raw values for MULTU/DIVU).
It also latches the result sign flags, the div-by-zero flag (op_b==0) and op.
Counter is cleared and the state moves to RUN.
RUN: one iteration per cycle for 32 cycles; then the state moves to FIX.
Multiply: 64-bit shift-add on the magnitudes.
Divide: restoring shift/trial-subtract on the magnitudes, producing a quotient and a remainder.
FIX (1 cycle):
Signed sign correction is applied.
Multiply: negate the 64-bit product iff the operand signs differ.
Divide: negate the quotient iff the operand signs differ; the remainder takes the dividend's sign.
Writes: multiply {HI,LO} = product; divide LO = quotient, HI = remainder.
done is registered high for the following cycle, and the state returns to IDLE.
Timing: start high in cycle 0 -> busy high in cycles 1-33, done high in cycle 34 only, new HI/LO visible from cycle 34. A new start is accepted in cycle 34.
HI/LO hold their previous values throughout RUN and FIX; working registers are separate.
start while busy: ignored; no queuing.
hi_we/lo_we while busy: ignored.
hi_we/lo_we in IDLE with start=0: write wr_data to the selected register at the clock edge. Both may be written in the same cycle. done is not asserted.
start together with hi_we/lo_we in IDLE: start wins; the writes are dropped.
Divide by zero (DIV or DIVU): no exception, same 34-cycle latency. The result is HI = op_a (raw, as latched) and LO = 32'hFFFF_FFFF, bypassing sign correction.
DIV 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0. This falls out of the magnitude arithmetic and requires no special case.
All arithmetic is modulo 2^64 (product) and 2^32 (quotient/remainder). No flags are produced.

Decomposition:
Package mips_muldiv_pkg holds:
typedef enum muldiv_op_t: MULT, MULTU, DIV, DIVU.
typedef enum muldiv_state_t: IDLE, RUN, FIX.
Constants: DIV0_LO = 32'hFFFF_FFFF and MULDIV_ITER = 32.
One sub-module is natural: mips_muldiv_step. It is purely combinational and computes one iteration (add-shift for multiply, trial-subtract-shift for divide) from the working accumulator/quotient/operand. The parent owns the FSM, counter, sign handling and HI/LO.

Test Plan:
1. MULTU op_a=0xFFFFFFFF, op_b=0xFFFFFFFF, start in cycle 0 -> busy cycles 1-33; done only in cycle 34; HI=0xFFFFFFFE, LO=0x00000001.
2. MULT op_a=0xFFFFFFFD (-3), op_b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
3. DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU op_a=7, op_b=2 -> LO=3, HI=1.
4. DIV op_a=0x80000000, op_b=0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU op_a=5, op_b=0 -> HI=5, LO=0xFFFFFFFF, done in cycle 34.
5. Idle MTHI wr_data=0x1234 -> HI=0x1234 next cycle, LO unchanged. During a DIVU, pulse start (new operands) and hi_we in cycle 10 -> both ignored; the original result lands in cycle 34.
6. rst high in cycle 15 of a MULTU with HI/LO preloaded to 0xAAAA/0x5555 -> cycle 16: busy=0, done=0, HI=LO=0; no done pulse in cycle 34.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mips_muldiv_pkg;

    localparam int unsigned MULDIV_W    = 32;
    localparam int unsigned MULDIV_ITER = 32;
    localparam logic [31:0] DIV0_LO     = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    // Two's-complement magnitude of a 32-bit value.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? 32'(-v) : v;
    endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One iteration of the multiplier (add-shift) or the restoring divider (trial-subtract-shift).
module mips_muldiv_step
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned W = MULDIV_W
) (
    input  logic           i_is_div,
    input  logic [2*W-1:0] i_acc,
    input  logic [W-1:0]   i_opnd,
    output logic [2*W-1:0] o_acc
);

    logic [W:0]   w_mul_sum;
    logic [W:0]   w_shifted;
    logic         w_ge;
    logic [W-1:0] w_rem;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        w_mul_sum = {1'b0, i_acc[2*W-1:W]} + (i_acc[0] ? (W+1)'(i_opnd) : (W+1)'(0));
        w_shifted = {i_acc[2*W-1:W], i_acc[W-1]};
        w_ge      = (w_shifted >= (W+1)'(i_opnd));
        w_rem     = w_ge ? W'(w_shifted - (W+1)'(i_opnd)) : w_shifted[W-1:0];
        if (i_is_div) begin
            o_acc = {w_rem, i_acc[W-2:0], w_ge};
        end else begin
            o_acc = {w_mul_sum, i_acc[W-1:1]};
        end
    end

endmodule

// File: rtl/mips_hilo_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module mips_hilo_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ITER   = 32
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(ITER) + 1;
    localparam int unsigned ACC_W = 2 * DATA_W;

    muldiv_state_t     r_state, w_state_nxt;
    muldiv_op_t        r_op,    w_op_nxt;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
    logic [ACC_W-1:0]  r_acc,   w_acc_nxt;
    logic [DATA_W-1:0] r_opnd,  w_opnd_nxt;
    logic [DATA_W-1:0] r_a_raw, w_a_raw_nxt;
    logic              r_neg_q, w_neg_q_nxt;
    logic              r_neg_r, w_neg_r_nxt;
    logic              r_div0,  w_div0_nxt;
    logic [DATA_W-1:0] r_hi,    w_hi_nxt;
    logic [DATA_W-1:0] r_lo,    w_lo_nxt;
    logic              r_done,  w_done_nxt;

    logic              w_signed;
    logic              w_sgn_a;
    logic              w_sgn_b;
    logic              w_run_div;
    logic [ACC_W-1:0]  w_step_acc;

    assign w_signed  = ~op[0];
    assign w_sgn_a   = w_signed & op_a[DATA_W-1];
    assign w_sgn_b   = w_signed & op_b[DATA_W-1];
    assign w_run_div = (r_op == DIV) || (r_op == DIVU);

    mips_muldiv_step #(.W(DATA_W)) u_step (
        .i_is_div (w_run_div),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_step_acc)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= MULT;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_a_raw <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
            r_opnd  <= w_opnd_nxt;
            r_a_raw <= w_a_raw_nxt;
            r_neg_q <= w_neg_q_nxt;
            r_neg_r <= w_neg_r_nxt;
            r_div0  <= w_div0_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_opnd_nxt  = r_opnd;
        w_a_raw_nxt = r_a_raw;
        w_neg_q_nxt = r_neg_q;
        w_neg_r_nxt = r_neg_r;
        w_div0_nxt  = r_div0;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            IDLE: begin
                // start takes priority over MTHI/MTLO in the same cycle.
                if (start) begin
                    w_op_nxt    = muldiv_op_t'(op);
                    w_acc_nxt   = {DATA_W'(0), (w_signed ? abs32(op_a) : op_a)};
                    w_opnd_nxt  = w_signed ? abs32(op_b) : op_b;
                    w_a_raw_nxt = op_a;
                    w_neg_q_nxt = w_sgn_a ^ w_sgn_b;
                    w_neg_r_nxt = w_sgn_a;
                    w_div0_nxt  = (op_b == DATA_W'(0));
                    w_cnt_nxt   = '0;
                    w_state_nxt = RUN;
                end else begin
                    if (hi_we) w_hi_nxt = wr_data;
                    if (lo_we) w_lo_nxt = wr_data;
                end
            end
            RUN: begin
                w_acc_nxt = w_step_acc;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(ITER - 1)) w_state_nxt = FIX;
            end
            FIX: begin
                // Divide-by-zero bypasses sign correction and returns the raw dividend.
                if (w_run_div) begin
                    if (r_div0) begin
                        w_hi_nxt = r_a_raw;
                        w_lo_nxt = DIV0_LO;
                    end else begin
                        w_lo_nxt = r_neg_q ? DATA_W'(-r_acc[DATA_W-1:0]) : r_acc[DATA_W-1:0];
                        w_hi_nxt = r_neg_r ? DATA_W'(-r_acc[ACC_W-1:DATA_W]) : r_acc[ACC_W-1:DATA_W];
                    end
                end else begin
                    {w_hi_nxt, w_lo_nxt} = r_neg_q ? ACC_W'(-r_acc) : r_acc;
                end
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mips_hilo_muldiv.sv
// Directed-vector bench for mips_hilo_muldiv: latency, arithmetic corners, MTHI/MTLO and reset abort.
module tb_mips_hilo_muldiv;

    logic        CLK = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int errors  = 0;

    mips_hilo_muldiv dut (
        .CLK     (CLK),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .op_a    (op_a),
        .op_b    (op_b),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 CLK = ~CLK;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
        tick(); tick();
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        vectors++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
        vectors++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
        rst = 1'b0;
        tick();
    endtask

    // Full busy/done timeline; ends sitting in cycle 34.
    task automatic test_multu_max();
        op = 2'b01; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            vectors++;
            if (busy !== (c <= 33)) begin errors++; $display("FAIL multu_busy c=%0d got %b exp %b", c, busy, (c <= 33)); end
            vectors++;
            if (done !== (c == 34)) begin errors++; $display("FAIL multu_done c=%0d got %b exp %b", c, done, (c == 34)); end
        end
        vectors++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", hi); end
        vectors++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", lo); end
    endtask

    // Launched in cycle 34 of the previous op: back-to-back acceptance.
    task automatic test_mult_signed();
        op = 2'b00; op_a = 32'hFFFF_FFFD; op_b = 32'd7; start = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (c == 1 || c == 33) begin
                vectors++;
                if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy c=%0d got %b exp 1", c, busy); end
            end
        end
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL mult_done got %b exp 1", done); end
        vectors++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
        vectors++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got %h exp ffffffeb", lo); end
    endtask

    task automatic test_div_signed();
        op = 2'b10; op_a = 32'hFFFF_FFF9; op_b = 32'd2; start = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c == 1) start = 1'b0;
        end
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL div_done got %b exp 1", done); end
        vectors++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", lo); end
        vectors++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", hi); end
        op = 2'b11; op_a = 32'd7; op_b = 32'd2; start = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c == 1) start = 1'b0;
        end
        vectors++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo got %h exp 3", lo); end
        vectors++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi got %h exp 1", hi); end
    endtask

    task automatic test_div_corner();
        op = 2'b10; op_a = 32'h8000_0000; op_b = 32'hFFFF_FFFF; start = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c == 1) start = 1'b0;
        end
        vectors++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL divmin_lo got %h exp 80000000", lo); end
        vectors++; if (hi !== 32'h0) begin errors++; $display("FAIL divmin_hi got %h exp 0", hi); end
        op = 2'b11; op_a = 32'd5; op_b = 32'd0; start = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            vectors++;
            if (done !== (c == 34)) begin errors++; $display("FAIL div0_done c=%0d got %b exp %b", c, done, (c == 34)); end
        end
        vectors++; if (hi !== 32'd5) begin errors++; $display("FAIL div0_hi got %h exp 5", hi); end
        vectors++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo got %h exp ffffffff", lo); end
        // Signed divide-by-zero keeps the raw negative dividend.
        op = 2'b10; op_a = 32'hFFFF_FFF0; op_b = 32'd0; start = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c == 1) start = 1'b0;
        end
        vectors++; if (hi !== 32'hFFFF_FFF0) begin errors++; $display("FAIL sdiv0_hi got %h exp fffffff0", hi); end
        vectors++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv0_lo got %h exp ffffffff", lo); end
    endtask

    task automatic test_mt_writes();
        tick();
        hi_we = 1'b1; wr_data = 32'h1234;
        tick();
        hi_we = 1'b0;
        vectors++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi got %h exp 1234", hi); end
        vectors++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mthi_lo got %h exp ffffffff", lo); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL mthi_done got %b exp 0", done); end
        lo_we = 1'b1; wr_data = 32'hBEEF;
        tick();
        lo_we = 1'b0;
        vectors++; if (lo !== 32'hBEEF) begin errors++; $display("FAIL mtlo_lo got %h exp beef", lo); end
        vectors++; if (hi !== 32'h1234) begin errors++; $display("FAIL mtlo_hi got %h exp 1234", hi); end
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h55;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        vectors++; if (hi !== 32'h55 || lo !== 32'h55) begin errors++; $display("FAIL mtboth got %h/%h exp 55/55", hi, lo); end
        // start together with writes: writes are dropped, HI/LO hold through the op.
        op = 2'b01; op_a = 32'd2; op_b = 32'd3; start = 1'b1;
        hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h77;
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c == 1) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
                vectors++;
                if (hi !== 32'h55 || busy !== 1'b1) begin errors++; $display("FAIL startwins_c1 got hi=%h busy=%b exp 55/1", hi, busy); end
            end
        end
        vectors++; if (hi !== 32'h0 || lo !== 32'd6) begin errors++; $display("FAIL startwins_res got %h/%h exp 0/6", hi, lo); end
    endtask

    task automatic test_busy_ignore();
        op = 2'b11; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (c == 10) begin
                start = 1'b1; op = 2'b01; op_a = 32'd3; op_b = 32'd3;
                hi_we = 1'b1; wr_data = 32'hDEAD;
            end
            if (c == 11) begin
                start = 1'b0; hi_we = 1'b0;
                vectors++;
                if (hi !== 32'h0) begin errors++; $display("FAIL busywe_hi got %h exp 0", hi); end
            end
            vectors++;
            if (done !== (c == 34)) begin errors++; $display("FAIL busyign_done c=%0d got %b exp %b", c, done, (c == 34)); end
        end
        vectors++; if (hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL busyign_res got %h/%h exp 2/e", hi, lo); end
        tick();
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL busyign_noqueue got busy=%b done=%b exp 0/0", busy, done); end
    endtask

    task automatic test_reset_abort();
        hi_we = 1'b1; wr_data = 32'hAAAA;
        tick();
        hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'h5555;
        tick();
        lo_we = 1'b0;
        vectors++; if (hi !== 32'hAAAA || lo !== 32'h5555) begin errors++; $display("FAIL preload got %h/%h exp aaaa/5555", hi, lo); end
        op = 2'b01; op_a = 32'd3; op_b = 32'd4; start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (c == 15) rst = 1'b1;
            if (c == 16) begin
                rst = 1'b0;
                vectors++;
                if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_ctl got busy=%b done=%b exp 0/0", busy, done); end
                vectors++;
                if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL abort_hilo got %h/%h exp 0/0", hi, lo); end
            end
            if (c > 16) begin
                vectors++;
                if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_nodone c=%0d got done=%b busy=%b exp 0/0", c, done, busy); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_div_signed();
        test_div_corner();
        test_mt_writes();
        test_busy_ignore();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
